frame_sync_ctrl: RTL and testbench
==================================

Name: frame_sync_ctrl

Overview:
Serial frame synchroniser and controller built around a programmable sync-word detector.
- Hunts a 1-bit stream for a configurable sync pattern (default 1101).
- After each sync word, sequences capture of a fixed-length payload.
- Verifies the sync word at every following frame boundary and maintains lock with flywheel tolerance.
- Sits between the serial receive front end and the frame consumer logic.

Parameters:
PAT_W, 4, sync pattern width in bits (>=2)
PAY_W, 8, payload bits per frame (>=1)
LOCK_CNT, 2, consecutive good sync words required to assert lock (>=1)
MISS_CNT, 2, consecutive bad sync words while locked that drop lock (>=1)

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_enable  input  1  1 = run, 0 = return to and hold in IDLE
i_cfg_load  input  1  load i_cfg_pattern into pattern register
i_cfg_pattern  input  PAT_W  new sync pattern; MSB is compared against the earliest-received bit
i_bit_valid  input  1  qualifies i_bit_in this cycle
i_bit_in  input  1  serial data bit
o_sync_hit  output  1  1-cycle pulse: sync word accepted
o_frame_valid  output  1  1-cycle pulse: o_frame_data updated
o_frame_data  output  PAY_W  last captured payload; first received bit is the MSB
o_locked  output  1  lock status
o_state  output  2  IDLE=0, HUNT=1, PAYLOAD=2, VERIFY=3

Behaviour:
- Reset (async): state IDLE; all outputs 0; pattern register = PAT_W'b...1101, low bits of 1101 (zero-extended when PAT_W>4); window, fill, bit, good and miss counters all 0.
- Config: i_cfg_load is honoured only in IDLE with i_enable=0; otherwise it is ignored. The pattern register is held across enable toggles.
- Bit acceptance: only a cycle with i_bit_valid=1 advances anything. With i_bit_valid=0 there is no state or counter change.
- Window: in every non-IDLE state, each accepted bit shifts into a PAT_W history window. The fill counter saturates at PAT_W.
- Output timing: all outputs are registered. Each pulse appears in the cycle after the edge that accepted the triggering bit.

IDLE:
- i_enable=1 -> HUNT.

HUNT:
- Match = fill>=PAT_W (counting the current bit) and {window[PAT_W-2:0], bit} == pattern.
- On match: pulse o_sync_hit; good=1; miss=0; bit counter=0; -> PAYLOAD.
- If LOCK_CNT==1, set o_locked in the same cycle as o_sync_hit.

PAYLOAD:
- Shift each accepted bit into the capture register.
- On the PAY_W-th bit: o_frame_data <= capture (including that bit); pulse o_frame_valid; bit counter=0; -> VERIFY.

VERIFY:
- Collect PAT_W bits. On the PAT_W-th bit, compare against the pattern.
- Good compare:
  - pulse o_sync_hit; good saturating increment; miss=0.
  - When good reaches LOCK_CNT, set o_locked, registered alongside o_sync_hit.
  - -> PAYLOAD.
- Bad compare while locked, with miss+1 < MISS_CNT (flywheel):
  - miss++; o_locked stays 1.
  - -> PAYLOAD; that frame is delivered normally.
- Bad compare otherwise:
  - o_locked=0; good=0; miss=0.
  - -> HUNT. The window is retained, so a match can occur on the very next bit.

Enable and reset:
- i_enable=0 in any state -> IDLE on the next edge.
  - Clears o_locked and all counters.
  - Discards any partial payload; o_frame_data holds its last value.
  - No pulses are generated.
- Async reset mid-operation forces all reset values immediately, including the pattern register.

Simultaneous events:
- i_enable falling overrides bit acceptance in the same cycle.
- i_cfg_load together with i_enable rising in IDLE: the load is taken and the state moves to HUNT.

Test Plan:
(All scenarios use the defaults PAT_W=4, PAY_W=8, LOCK_CNT=2, MISS_CNT=2.)
1. Reset: hold i_rst_n=0 -> all outputs 0, o_state=0. Release, enable=1 -> o_state=1 next cycle.
2. Hunt + first frame: bits 0,1,1,1,0,1 -> o_sync_hit one cycle after bit 6, o_locked=0. Then payload A5 (10100101) -> o_frame_valid pulse, o_frame_data=8'hA5, o_state=3.
3. Lock: sync 1101, then payload 8'h3C -> o_sync_hit with o_locked=1 in the same cycle; o_frame_data=8'h3C.
4. Flywheel and loss, continuing from scenario 3:
   - Sync 1001 -> no o_sync_hit, o_locked stays 1; payload 8'h0F delivered.
   - Sync 0000 -> o_locked=0, o_state=1, no frame.
5. Gaps and reset: random i_bit_valid gaps during scenario 2 -> identical outputs.
   - i_rst_n low mid-PAYLOAD -> outputs 0 immediately; no stale o_frame_valid after release.
6. Config:
   - i_cfg_load 4'b1011 with enable=1 -> ignored; stream 1101 still hits.
   - Same load in IDLE with enable=0, then enable -> stream 1101 misses and 1011 hits.

Source files
------------

// File: rtl/frame_sync_ctrl.sv
// Serial frame synchroniser: hunts a 1-bit stream for a programmable sync word,
// captures a fixed-length payload per frame and tracks lock with flywheel tolerance.
module frame_sync_ctrl #(
  parameter int unsigned PAT_W    = 4,
  parameter int unsigned PAY_W    = 8,
  parameter int unsigned LOCK_CNT = 2,
  parameter int unsigned MISS_CNT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_cfg_load,
  input  logic [PAT_W-1:0] i_cfg_pattern,
  input  logic             i_bit_valid,
  input  logic             i_bit_in,
  output logic             o_sync_hit,
  output logic             o_frame_valid,
  output logic [PAY_W-1:0] o_frame_data,
  output logic             o_locked,
  output logic [1:0]       o_state
);

  localparam int unsigned FILL_W  = $clog2(PAT_W + 1);
  localparam int unsigned BIT_MAX = (PAY_W > PAT_W) ? PAY_W : PAT_W;
  localparam int unsigned BIT_W   = $clog2(BIT_MAX + 1);
  localparam int unsigned GOOD_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W  = $clog2(MISS_CNT + 1);
  localparam logic [3:0]  DEF_PAT = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HUNT    = 2'd1,
    S_PAYLOAD = 2'd2,
    S_VERIFY  = 2'd3
  } state_t;

  state_t             r_state;
  logic [PAT_W-1:0]   r_pattern;
  logic [PAT_W-1:0]   r_window;
  logic [FILL_W-1:0]  r_fill;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [PAY_W-1:0]   r_cap;
  logic [PAY_W-1:0]   r_frame_data;
  logic [GOOD_W-1:0]  r_good;
  logic [MISS_W-1:0]  r_miss;
  logic               r_locked;
  logic               r_sync_hit;
  logic               r_frame_valid;

  logic [PAT_W-1:0]   w_win_next;
  logic [PAY_W-1:0]   w_cap_next;
  logic               w_hunt_match;
  logic               w_verify_good;
  logic [GOOD_W-1:0]  w_good_inc;

  // History and capture views including the bit being accepted this cycle
  assign w_win_next    = PAT_W'({r_window, i_bit_in});
  assign w_cap_next    = PAY_W'({r_cap, i_bit_in});
  assign w_hunt_match  = (r_fill >= FILL_W'(PAT_W - 1)) && (w_win_next == r_pattern);
  assign w_verify_good = (w_win_next == r_pattern);
  assign w_good_inc    = (r_good >= GOOD_W'(LOCK_CNT)) ? r_good : r_good + GOOD_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_pattern     <= PAT_W'(DEF_PAT);
      r_window      <= '0;
      r_fill        <= '0;
      r_bit_cnt     <= '0;
      r_cap         <= '0;
      r_frame_data  <= '0;
      r_good        <= '0;
      r_miss        <= '0;
      r_locked      <= 1'b0;
      r_sync_hit    <= 1'b0;
      r_frame_valid <= 1'b0;
    end else begin
      r_sync_hit    <= 1'b0;
      r_frame_valid <= 1'b0;
      if (!i_enable) begin
        // Disable wins over any bit this cycle; frame data is kept
        r_state   <= S_IDLE;
        r_locked  <= 1'b0;
        r_window  <= '0;
        r_fill    <= '0;
        r_bit_cnt <= '0;
        r_good    <= '0;
        r_miss    <= '0;
        if (r_state == S_IDLE && i_cfg_load) r_pattern <= i_cfg_pattern;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_cfg_load) r_pattern <= i_cfg_pattern;
            r_state <= S_HUNT;
          end
          default: begin
            if (i_bit_valid) begin
              r_window <= w_win_next;
              if (r_fill != FILL_W'(PAT_W)) r_fill <= r_fill + FILL_W'(1);
              case (r_state)
                S_HUNT: begin
                  if (w_hunt_match) begin
                    r_sync_hit <= 1'b1;
                    r_good     <= GOOD_W'(1);
                    r_miss     <= '0;
                    r_bit_cnt  <= '0;
                    r_state    <= S_PAYLOAD;
                    if (LOCK_CNT == 1) r_locked <= 1'b1;
                  end
                end
                S_PAYLOAD: begin
                  r_cap <= w_cap_next;
                  if (r_bit_cnt == BIT_W'(PAY_W - 1)) begin
                    r_frame_data  <= w_cap_next;
                    r_frame_valid <= 1'b1;
                    r_bit_cnt     <= '0;
                    r_state       <= S_VERIFY;
                  end else begin
                    r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                  end
                end
                S_VERIFY: begin
                  if (r_bit_cnt == BIT_W'(PAT_W - 1)) begin
                    r_bit_cnt <= '0;
                    if (w_verify_good) begin
                      r_sync_hit <= 1'b1;
                      r_good     <= w_good_inc;
                      r_miss     <= '0;
                      r_state    <= S_PAYLOAD;
                      if (w_good_inc >= GOOD_W'(LOCK_CNT)) r_locked <= 1'b1;
                    end else if (r_locked && (r_miss < MISS_W'(MISS_CNT - 1))) begin
                      // Flywheel: tolerate an isolated bad sync word while locked
                      r_miss  <= r_miss + MISS_W'(1);
                      r_state <= S_PAYLOAD;
                    end else begin
                      r_locked <= 1'b0;
                      r_good   <= '0;
                      r_miss   <= '0;
                      r_state  <= S_HUNT;
                    end
                  end else begin
                    r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                  end
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

  assign o_sync_hit    = r_sync_hit;
  assign o_frame_valid = r_frame_valid;
  assign o_frame_data  = r_frame_data;
  assign o_locked      = r_locked;
  assign o_state       = r_state;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Scoreboard bench for frame_sync_ctrl: expected sync hits and frames are queued
// as stimulus is driven and checked by a monitor when the DUT pulses.
module tb_frame_sync_ctrl;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_enable;
  logic       i_cfg_load;
  logic [3:0] i_cfg_pattern;
  logic       i_bit_valid;
  logic       i_bit_in;
  logic       o_sync_hit;
  logic       o_frame_valid;
  logic [7:0] o_frame_data;
  logic       o_locked;
  logic [1:0] o_state;

  int n_checks = 0;
  int n_fail   = 0;
  bit gap_en   = 1'b0;

  logic       sync_q[$];
  logic [7:0] frame_q[$];

  frame_sync_ctrl #(.PAT_W(4), .PAY_W(8), .LOCK_CNT(2), .MISS_CNT(2)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_enable      (i_enable),
    .i_cfg_load    (i_cfg_load),
    .i_cfg_pattern (i_cfg_pattern),
    .i_bit_valid   (i_bit_valid),
    .i_bit_in      (i_bit_in),
    .o_sync_hit    (o_sync_hit),
    .o_frame_valid (o_frame_valid),
    .o_frame_data  (o_frame_data),
    .o_locked      (o_locked),
    .o_state       (o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Monitor: every pulse must match the head of its queue
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_sync_hit) begin
        n_checks++;
        if (sync_q.size() == 0) begin
          n_fail++;
          $display("FAIL sync_hit_unexpected: got pulse, required none (t=%0t)", $time);
        end else begin
          logic exp_lock;
          exp_lock = sync_q.pop_front();
          if (o_locked !== exp_lock) begin
            n_fail++;
            $display("FAIL sync_hit_locked: got %b, required %b (t=%0t)", o_locked, exp_lock, $time);
          end
        end
      end
      if (o_frame_valid) begin
        n_checks++;
        if (frame_q.size() == 0) begin
          n_fail++;
          $display("FAIL frame_unexpected: got data %h, required no frame (t=%0t)", o_frame_data, $time);
        end else begin
          logic [7:0] exp_data;
          exp_data = frame_q.pop_front();
          if (o_frame_data !== exp_data) begin
            n_fail++;
            $display("FAIL frame_data: got %h, required %h (t=%0t)", o_frame_data, exp_data, $time);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    if (gap_en) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge i_clk);
        i_bit_valid = 1'b0;
        i_bit_in    = 1'($urandom);
      end
    end
    @(negedge i_clk);
    i_bit_valid = 1'b1;
    i_bit_in    = b;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge i_clk);
      i_bit_valid = 1'b0;
    end
  endtask

  task automatic check_state(input string name, input logic [1:0] exp_st, input logic exp_lock);
    n_checks++;
    if (o_state !== exp_st) begin
      n_fail++;
      $display("FAIL %s_state: got %0d, required %0d", name, o_state, exp_st);
    end
    n_checks++;
    if (o_locked !== exp_lock) begin
      n_fail++;
      $display("FAIL %s_locked: got %b, required %b", name, o_locked, exp_lock);
    end
  endtask

  task automatic check_drained(input string name);
    #1;
    n_checks++;
    if (sync_q.size() != 0 || frame_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained: got %0d syncs/%0d frames pending, required 0/0",
               name, sync_q.size(), frame_q.size());
      sync_q.delete();
      frame_q.delete();
    end
  endtask

  task automatic toggle_enable();
    @(negedge i_clk);
    i_bit_valid = 1'b0;
    i_enable    = 1'b0;
    @(negedge i_clk);
    i_enable = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_enable = 1'b0; i_cfg_load = 1'b0; i_cfg_pattern = 4'h0;
    i_bit_valid = 1'b0; i_bit_in = 1'b0;
    repeat (3) @(negedge i_clk);
    n_checks++;
    if ({o_sync_hit, o_frame_valid, o_frame_data, o_locked, o_state} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b %b %h %b %0d, required all 0",
               o_sync_hit, o_frame_valid, o_frame_data, o_locked, o_state);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    i_enable = 1'b1;
    @(negedge i_clk);
    check_state("reset_enable", 2'd1, 1'b0);
  endtask

  task automatic test_first_frame(input string name);
    sync_q.push_back(1'b0);
    send_bits(8'b00_011101, 6);
    idle(1);
    check_state({name, "_sync"}, 2'd2, 1'b0);
    frame_q.push_back(8'hA5);
    send_bits(8'hA5, 8);
    idle(1);
    check_state({name, "_frame"}, 2'd3, 1'b0);
    check_drained(name);
  endtask

  task automatic test_lock();
    sync_q.push_back(1'b1);
    send_bits(8'b0000_1101, 4);
    frame_q.push_back(8'h3C);
    send_bits(8'h3C, 8);
    idle(1);
    check_state("lock", 2'd3, 1'b1);
    check_drained("lock");
  endtask

  task automatic test_flywheel();
    send_bits(8'b0000_1001, 4);
    idle(1);
    check_state("flywheel_sync", 2'd2, 1'b1);
    frame_q.push_back(8'h0F);
    send_bits(8'h0F, 8);
    idle(1);
    check_state("flywheel_frame", 2'd3, 1'b1);
    send_bits(8'b0000_0000, 4);
    idle(3);
    check_state("loss", 2'd1, 1'b0);
    check_drained("flywheel");
  endtask

  task automatic test_gaps_reset();
    toggle_enable();
    check_state("gaps_restart", 2'd1, 1'b0);
    gap_en = 1'b1;
    test_first_frame("gaps");
    gap_en = 1'b0;
    toggle_enable();
    sync_q.push_back(1'b0);
    send_bits(8'b0000_1101, 4);
    send_bits(8'b0000_1010, 4);
    #2;
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_sync_hit, o_frame_valid, o_frame_data, o_locked, o_state} !== 13'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %b %b %h %b %0d, required all 0",
               o_sync_hit, o_frame_valid, o_frame_data, o_locked, o_state);
    end
    i_bit_valid = 1'b0;
    i_enable    = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle(2);
    i_enable = 1'b1;
    idle(12);
    check_state("midreset_after", 2'd1, 1'b0);
    check_drained("midreset");
  endtask

  task automatic test_config();
    @(negedge i_clk);
    i_cfg_load = 1'b1; i_cfg_pattern = 4'b1011;
    @(negedge i_clk);
    i_cfg_load = 1'b0;
    sync_q.push_back(1'b0);
    send_bits(8'b0000_1101, 4);
    idle(1);
    check_state("cfg_ignored", 2'd2, 1'b0);
    @(negedge i_clk);
    i_enable = 1'b0;
    @(negedge i_clk);
    check_state("cfg_idle", 2'd0, 1'b0);
    i_cfg_load = 1'b1;
    @(negedge i_clk);
    i_cfg_load = 1'b0;
    i_enable   = 1'b1;
    @(negedge i_clk);
    send_bits(8'b0000_1101, 4);
    idle(1);
    check_state("cfg_old_miss", 2'd1, 1'b0);
    toggle_enable();
    sync_q.push_back(1'b0);
    send_bits(8'b0000_1011, 4);
    idle(1);
    check_state("cfg_new_hit", 2'd2, 1'b0);
    check_drained("cfg");
  endtask

  initial begin
    test_reset();
    test_first_frame("first");
    test_lock();
    test_flywheel();
    test_gaps_reset();
    test_config();
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
